dma_chan_sched: RTL and testbench

- Registered channel scheduler that sits between the peripheral request synchronisers / memory-channel enables and the DMA engine's source/destination request interface.
- Each cycle in IDLE it picks one eligible channel by programmable priority, with round-robin tie-break and starvation aging.
- It holds that grant across the whole engine service (request → accept → done) and returns a one-cycle ACK pulse to the served channel.
- Channels 0-3 are peripherals P0-P3; channels 4-5 are memory channels M0-M1.

---
 rtl/dma_sched_pkg.sv | 28 ++
 rtl/dma_pri_pick.sv | 72 +++++++
 rtl/dma_chan_sched.sv | 156 +++++++++++++++
 tb/tb_dma_chan_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared definitions for the DMA channel scheduler.
//   - sched_state_t  : scheduler FSM states
//   - DEF_*          : default channel count, priority width, age width, age limit
//   - IDW            : width of a binary channel index (gnt_id_o)
//   - P0..P3, M0, M1 : channel index constants (peripherals, memory channels)
package dma_sched_pkg;

   localparam int DEF_NCH       = 6;
   localparam int DEF_PW        = 3;
   localparam int DEF_AW        = 4;
   localparam int DEF_AGE_LIMIT = 15;
   localparam int IDW           = 3;

   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P3 = 3;
   localparam int M0 = 4;
   localparam int M1 = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      ACK  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/dma_pri_pick.sv
// Combinational channel picker.
// Candidate set is the boosted eligible channels if any exist, otherwise the
// eligible channels sharing the highest priority. The winner is the first
// candidate found scanning upward from rr_ptr+1 (modulo NCH).
// Ports:
//   elig       in  NCH     eligible channels
//   boost      in  NCH     channels whose age reached the limit
//   pri        in  NCH*PW  packed priorities, channel k at [k*PW +: PW]
//   rr_ptr     in  IDW     last granted channel
//   pick_oh    out NCH     one-hot winner
//   pick_id    out IDW     binary winner index
//   pick_valid out 1       a winner exists
module dma_pri_pick
   import dma_sched_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int PW  = DEF_PW
) (
   input  logic [NCH-1:0]    elig,
   input  logic [NCH-1:0]    boost,
   input  logic [NCH*PW-1:0] pri,
   input  logic [IDW-1:0]    rr_ptr,
   output logic [NCH-1:0]    pick_oh,
   output logic [IDW-1:0]    pick_id,
   output logic              pick_valid
);

   logic [PW-1:0]  pri_arr [NCH];
   logic [NCH-1:0] boost_elig;
   logic [NCH-1:0] cand;
   logic [PW-1:0]  max_pri;

   assign boost_elig = elig & boost;

   // Unsigned max over eligible channels only.
   always_comb begin
      max_pri = '0;
      for (int k = 0; k < NCH; k++) begin
         if (elig[k] && (pri_arr[k] > max_pri)) begin
            max_pri = pri_arr[k];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_cand
         assign pri_arr[gi] = pri[gi*PW +: PW];
         // Starving channels pre-empt the priority order entirely.
         assign cand[gi] = (|boost_elig) ? boost_elig[gi]
                                         : (elig[gi] && (pri_arr[gi] == max_pri));
      end
   endgenerate

   // Rotating scan: the channel just served is looked at last.
   always_comb begin
      logic [IDW-1:0] idx;
      pick_oh    = '0;
      pick_id    = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx = IDW'((int'(rr_ptr) + i) % NCH);
         if (!pick_valid && cand[idx]) begin
            pick_valid   = 1'b1;
            pick_oh[idx] = 1'b1;
            pick_id      = idx;
         end
      end
   end

endmodule

// File: rtl/dma_chan_sched.sv
// DMA channel scheduler: arbitrates eligible channels in IDLE, holds the
// grant through the engine request/accept/done handshake and pulses a
// one-cycle completion ACK to the served channel.
// Ports:
//   clk_i, resetn_i        clock, async active-low reset
//   ch_req_i, ch_en_i      per-channel request level and enable
//   ch_pri_i               packed per-channel priorities (larger wins)
//   eng_req_o              service request to the engine (REQ state only)
//   eng_ack_i, eng_done_i  engine accept / finish
//   gnt_o, gnt_id_o        one-hot grant and its binary index
//   ch_ack_o               one-cycle completion pulse to served channel
//   busy_o                 scheduler not idle
module dma_chan_sched
   import dma_sched_pkg::*;
#(
   parameter int NCH       = DEF_NCH,
   parameter int PW        = DEF_PW,
   parameter int AW        = DEF_AW,
   parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic [NCH-1:0]    ch_req_i,
   input  logic [NCH-1:0]    ch_en_i,
   input  logic [NCH*PW-1:0] ch_pri_i,
   output logic              eng_req_o,
   input  logic              eng_ack_i,
   input  logic              eng_done_i,
   output logic [NCH-1:0]    gnt_o,
   output logic [2:0]        gnt_id_o,
   output logic [NCH-1:0]    ch_ack_o,
   output logic              busy_o
);

   sched_state_t   state_reg, state_next;
   logic [NCH-1:0] gnt_reg, gnt_next;
   logic [IDW-1:0] gnt_id_reg, gnt_id_next;
   logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [AW-1:0]  age_reg [NCH];

   logic [NCH-1:0] elig;
   logic [NCH-1:0] boost;
   logic [NCH-1:0] pick_oh;
   logic [IDW-1:0] pick_id;
   logic           pick_valid;
   logic           arb_fire;

   assign elig     = ch_req_i & ch_en_i;
   assign arb_fire = (state_reg == IDLE) && pick_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_boost
         assign boost[gi] = (age_reg[gi] == AW'(AGE_LIMIT));
      end
   endgenerate

   dma_pri_pick #(
      .NCH (NCH),
      .PW  (PW)
   ) u_pick (
      .elig       (elig),
      .boost      (boost),
      .pri        (ch_pri_i),
      .rr_ptr     (rr_ptr_reg),
      .pick_oh    (pick_oh),
      .pick_id    (pick_id),
      .pick_valid (pick_valid)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_reg  <= IDLE;
         gnt_reg    <= '0;
         gnt_id_reg <= '0;
         // Channel 0 wins the first tie after reset.
         rr_ptr_reg <= IDW'(NCH - 1);
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         gnt_id_reg <= gnt_id_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // Ages only move on an arbitration; a channel that stops being eligible
   // loses its accumulated age regardless of state.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int k = 0; k < NCH; k++) begin
            age_reg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (!elig[k]) begin
               age_reg[k] <= '0;
            end else if (arb_fire) begin
               if (pick_oh[k]) begin
                  age_reg[k] <= '0;
               end else if (age_reg[k] != AW'(AGE_LIMIT)) begin
                  age_reg[k] <= age_reg[k] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      gnt_id_next = gnt_id_reg;
      rr_ptr_next = rr_ptr_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               gnt_next    = pick_oh;
               gnt_id_next = pick_id;
               rr_ptr_next = pick_id;
               state_next  = REQ;
            end
         end
         REQ: begin
            // Engine acceptance wins over a simultaneous request drop.
            if (eng_ack_i) begin
               state_next = eng_done_i ? ACK : XFER;
            end else if (!(|(elig & gnt_reg))) begin
               state_next  = IDLE;
               gnt_next    = '0;
               gnt_id_next = '0;
            end
         end
         XFER: begin
            if (eng_done_i) begin
               state_next = ACK;
            end
         end
         ACK: begin
            state_next  = IDLE;
            gnt_next    = '0;
            gnt_id_next = '0;
         end
         default: begin
            state_next  = IDLE;
            gnt_next    = '0;
            gnt_id_next = '0;
         end
      endcase
   end

   assign eng_req_o = (state_reg == REQ);
   assign gnt_o     = gnt_reg;
   assign gnt_id_o  = gnt_id_reg;
   assign ch_ack_o  = (state_reg == ACK) ? gnt_reg : '0;
   assign busy_o    = (state_reg != IDLE);

endmodule

// File: tb/tb_dma_chan_sched.sv
`timescale 1ns/1ps
module tb_dma_chan_sched;
   import dma_sched_pkg::*;

   localparam int NCH = 6;
   localparam int PW  = 3;
   localparam int LIM = 15;

   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_XFER = 2;
   localparam int PH_ACK  = 3;

   logic              clk_i      = 1'b0;
   logic              resetn_i   = 1'b0;
   logic [NCH-1:0]    ch_req_i   = '0;
   logic [NCH-1:0]    ch_en_i    = '0;
   logic [NCH*PW-1:0] ch_pri_i   = '0;
   logic              eng_ack_i  = 1'b0;
   logic              eng_done_i = 1'b0;
   logic              eng_req_o;
   logic [NCH-1:0]    gnt_o;
   logic [2:0]        gnt_id_o;
   logic [NCH-1:0]    ch_ack_o;
   logic              busy_o;

   int checks = 0;
   int errors = 0;

   // Reference model: phase of the current service, granted channel
   // (-1 = none), last winner, and per-channel loss counts.
   int m_phase;
   int m_gnt;
   int m_rr;
   int m_age [NCH];

   dma_chan_sched #(
      .NCH       (NCH),
      .PW        (PW),
      .AW        (4),
      .AGE_LIMIT (LIM)
   ) dut (
      .clk_i      (clk_i),
      .resetn_i   (resetn_i),
      .ch_req_i   (ch_req_i),
      .ch_en_i    (ch_en_i),
      .ch_pri_i   (ch_pri_i),
      .eng_req_o  (eng_req_o),
      .eng_ack_i  (eng_ack_i),
      .eng_done_i (eng_done_i),
      .gnt_o      (gnt_o),
      .gnt_id_o   (gnt_id_o),
      .ch_ack_o   (ch_ack_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int model_pick(input logic [NCH-1:0] el, input logic [NCH*PW-1:0] pri);
      bit any_boost;
      int maxp;
      int k;
      int p;
      any_boost = 1'b0;
      maxp = -1;
      for (int c = 0; c < NCH; c++) begin
         if (el[c]) begin
            if (m_age[c] >= LIM) any_boost = 1'b1;
            p = int'(pri[c*PW +: PW]);
            if (p > maxp) maxp = p;
         end
      end
      for (int off = 1; off <= NCH; off++) begin
         k = (m_rr + off) % NCH;
         if (el[k]) begin
            if (any_boost ? (m_age[k] >= LIM) : (int'(pri[k*PW +: PW]) == maxp)) return k;
         end
      end
      return -1;
   endfunction

   function automatic logic [NCH-1:0] exp_gnt();
      logic [NCH-1:0] v;
      v = '0;
      if (m_gnt >= 0) v[m_gnt] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_gnt   = -1;
      m_rr    = NCH - 1;
      for (int c = 0; c < NCH; c++) m_age[c] = 0;
   endtask

   // Advance the model by the clock edge about to happen, using current inputs.
   task automatic model_step();
      logic [NCH-1:0] el;
      int p;
      el = ch_req_i & ch_en_i;
      p  = -1;
      case (m_phase)
         PH_IDLE: begin
            if (el != '0) begin
               p       = model_pick(el, ch_pri_i);
               m_gnt   = p;
               m_rr    = p;
               m_phase = PH_REQ;
            end
         end
         PH_REQ: begin
            if (eng_ack_i) begin
               m_phase = eng_done_i ? PH_ACK : PH_XFER;
            end else if (!el[m_gnt]) begin
               m_phase = PH_IDLE;
               m_gnt   = -1;
            end
         end
         PH_XFER: begin
            if (eng_done_i) m_phase = PH_ACK;
         end
         default: begin
            m_phase = PH_IDLE;
            m_gnt   = -1;
         end
      endcase
      for (int c = 0; c < NCH; c++) begin
         if (!el[c]) m_age[c] = 0;
         else if (p >= 0) m_age[c] = (c == p) ? 0 : ((m_age[c] < LIM) ? m_age[c] + 1 : LIM);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      resetn_i   = 1'b0;
      ch_req_i   = '0;
      ch_en_i    = '0;
      eng_ack_i  = 1'b0;
      eng_done_i = 1'b0;
      model_reset();
      @(posedge clk_i);
      #1;
      resetn_i = 1'b1;
   endtask

   task automatic serve();
      eng_ack_i  = 1'b1;
      eng_done_i = 1'b1;
      tick();
      eng_ack_i  = 1'b0;
      eng_done_i = 1'b0;
      tick();
   endtask

   task automatic wait_grant(output int id, output bit ok);
      ok = 1'b0;
      id = -1;
      for (int n = 0; n < 20; n++) begin
         if (eng_req_o === 1'b1) begin
            ok = 1'b1;
            id = int'(gnt_id_o);
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      @(posedge clk_i);
      #1;
      checks++; if (eng_req_o !== 1'b0) begin errors++; $display("FAIL reset_eng_req: got %b want 0", eng_req_o); end
      checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 000000", gnt_o); end
      checks++; if (gnt_id_o !== 3'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id_o); end
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL reset_ch_ack: got %b want 000000", ch_ack_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      $display("reset: outputs checked");
   endtask

   task automatic test_priority();
      apply_reset();
      ch_pri_i = '0;
      ch_pri_i[P0*PW +: PW] = 3'd1;
      ch_pri_i[P2*PW +: PW] = 3'd5;
      ch_pri_i[M0*PW +: PW] = 3'd3;
      ch_req_i = 6'b010101;
      ch_en_i  = 6'b010101;
      checks++; if (eng_req_o !== 1'b0) begin errors++; $display("FAIL pri_req_early: got %b want 0", eng_req_o); end
      tick();
      checks++; if (eng_req_o !== 1'b1) begin errors++; $display("FAIL pri_req: got %b want 1", eng_req_o); end
      checks++; if (gnt_id_o !== 3'd2) begin errors++; $display("FAIL pri_gnt_id: got %0d want 2", gnt_id_o); end
      checks++; if (gnt_o !== 6'b000100) begin errors++; $display("FAIL pri_gnt: got %b want 000100", gnt_o); end
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      checks++; if (eng_req_o !== 1'b0) begin errors++; $display("FAIL pri_xfer_req: got %b want 0", eng_req_o); end
      checks++; if (gnt_o !== 6'b000100) begin errors++; $display("FAIL pri_xfer_gnt: got %b want 000100", gnt_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL pri_early_ack: got %b want 000000", ch_ack_o); end
      end
      eng_done_i = 1'b1;
      tick();
      eng_done_i = 1'b0;
      checks++; if (ch_ack_o !== 6'b000100) begin errors++; $display("FAIL pri_ack: got %b want 000100", ch_ack_o); end
      ch_req_i = '0;
      ch_en_i  = '0;
      tick();
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL pri_ack_len: got %b want 000000", ch_ack_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pri_idle: got busy %b want 0", busy_o); end
      checks++; if (gnt_o !== '0) begin errors++; $display("FAIL pri_gnt_clr: got %b want 000000", gnt_o); end
      $display("priority: served ch 2");
   endtask

   task automatic test_round_robin();
      int exp_order [7] = '{0, 1, 2, 3, 4, 5, 0};
      int id;
      bit ok;
      apply_reset();
      ch_pri_i = {NCH{3'd4}};
      ch_req_i = '1;
      ch_en_i  = '1;
      for (int i = 0; i < 7; i++) begin
         wait_grant(id, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rr_timeout: service %0d got no request want ch %0d", i, exp_order[i]); end
         else if (id != exp_order[i]) begin errors++; $display("FAIL rr_order: service %0d got ch %0d want ch %0d", i, id, exp_order[i]); end
         $display("round_robin: service %0d granted ch %0d", i, id);
         serve();
      end
      ch_req_i = '0;
      ch_en_i  = '0;
   endtask

   task automatic test_aging();
      int id;
      int want;
      bit ok;
      apply_reset();
      ch_pri_i = '0;
      ch_pri_i[P0*PW +: PW] = 3'd7;
      ch_pri_i[M1*PW +: PW] = 3'd0;
      ch_req_i = 6'b100001;
      ch_en_i  = 6'b100001;
      for (int i = 1; i <= 17; i++) begin
         want = (i == 16) ? M1 : P0;
         wait_grant(id, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL age_timeout: arbitration %0d got no request want ch %0d", i, want); end
         else if (id != want) begin errors++; $display("FAIL age_grant: arbitration %0d got ch %0d want ch %0d", i, id, want); end
         $display("aging: arbitration %0d granted ch %0d", i, id);
         serve();
      end
      ch_req_i = '0;
      ch_en_i  = '0;
   endtask

   task automatic test_abort();
      apply_reset();
      ch_pri_i = '0;
      ch_pri_i[P1*PW +: PW] = 3'd6;
      ch_pri_i[P3*PW +: PW] = 3'd1;
      ch_req_i = 6'b001010;
      ch_en_i  = 6'b001010;
      tick();
      checks++; if (gnt_id_o !== 3'd1) begin errors++; $display("FAIL abort_first: got %0d want 1", gnt_id_o); end
      ch_en_i[P1] = 1'b0;
      tick();
      checks++; if (eng_req_o !== 1'b0) begin errors++; $display("FAIL abort_req: got %b want 0", eng_req_o); end
      checks++; if (gnt_o !== '0) begin errors++; $display("FAIL abort_gnt: got %b want 000000", gnt_o); end
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL abort_ack: got %b want 000000", ch_ack_o); end
      tick();
      checks++; if (gnt_id_o !== 3'd3 || eng_req_o !== 1'b1) begin errors++; $display("FAIL abort_next: got ch %0d req %b want ch 3 req 1", gnt_id_o, eng_req_o); end
      $display("abort: ch 1 dropped, ch 3 granted");
      ch_req_i = '0;
      ch_en_i  = '0;
   endtask

   task automatic test_ack_done_same();
      apply_reset();
      ch_pri_i = {NCH{3'd2}};
      ch_req_i = 6'b000100;
      ch_en_i  = 6'b000100;
      tick();
      eng_done_i = 1'b1;
      tick();
      checks++; if (eng_req_o !== 1'b1 || gnt_id_o !== 3'd2) begin errors++; $display("FAIL done_alone: got req %b ch %0d want req 1 ch 2", eng_req_o, gnt_id_o); end
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL done_alone_ack: got %b want 000000", ch_ack_o); end
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i  = 1'b0;
      eng_done_i = 1'b0;
      ch_req_i   = '0;
      checks++; if (ch_ack_o !== 6'b000100) begin errors++; $display("FAIL same_ack: got %b want 000100", ch_ack_o); end
      checks++; if (eng_req_o !== 1'b0) begin errors++; $display("FAIL same_req: got %b want 0", eng_req_o); end
      tick();
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL same_ack_len: got %b want 000000", ch_ack_o); end
      $display("ack_done_same: served ch 2");
      ch_en_i = '0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      ch_pri_i = {NCH{3'd1}};
      ch_req_i = 6'b000001;
      ch_en_i  = 6'b000001;
      tick();
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      checks++; if (busy_o !== 1'b1 || gnt_o !== 6'b000001) begin errors++; $display("FAIL arst_xfer: got busy %b gnt %b want busy 1 gnt 000001", busy_o, gnt_o); end
      #3;
      resetn_i   = 1'b0;
      eng_done_i = 1'b1;
      #1;
      checks++; if ({eng_req_o, gnt_o, gnt_id_o, ch_ack_o, busy_o} !== '0) begin
         errors++; $display("FAIL arst_outputs: got req %b gnt %b id %0d ack %b busy %b want all 0", eng_req_o, gnt_o, gnt_id_o, ch_ack_o, busy_o);
      end
      model_reset();
      @(posedge clk_i);
      #1;
      checks++; if (ch_ack_o !== '0) begin errors++; $display("FAIL arst_no_ack: got %b want 000000", ch_ack_o); end
      eng_done_i = 1'b0;
      ch_req_i   = 6'b001000;
      ch_en_i    = 6'b001000;
      resetn_i   = 1'b1;
      tick();
      checks++; if (gnt_id_o !== 3'd3 || gnt_o !== 6'b001000 || eng_req_o !== 1'b1) begin
         errors++; $display("FAIL arst_regrant: got ch %0d gnt %b req %b want ch 3 gnt 001000 req 1", gnt_id_o, gnt_o, eng_req_o);
      end
      $display("async_reset: ch 3 granted after release");
      ch_req_i = '0;
      ch_en_i  = '0;
   endtask

   task automatic test_random();
      logic [NCH-1:0] eg;
      logic [NCH-1:0] ea;
      int eid;
      apply_reset();
      ch_pri_i = NCH*PW'($urandom);
      for (int cyc = 0; cyc < 600; cyc++) begin
         ch_req_i   = NCH'($urandom | $urandom);
         ch_en_i    = NCH'($urandom | $urandom | $urandom);
         eng_ack_i  = ($urandom_range(0, 3) == 0);
         eng_done_i = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) ch_pri_i = NCH*PW'($urandom);
         tick();
         eg  = exp_gnt();
         ea  = (m_phase == PH_ACK) ? eg : '0;
         eid = (m_gnt >= 0) ? m_gnt : 0;
         checks++; if (eng_req_o !== (m_phase == PH_REQ)) begin errors++; $display("FAIL rand_req: cycle %0d got %b want %b", cyc, eng_req_o, (m_phase == PH_REQ)); end
         checks++; if (gnt_o !== eg) begin errors++; $display("FAIL rand_gnt: cycle %0d got %b want %b", cyc, gnt_o, eg); end
         checks++; if (int'(gnt_id_o) != eid) begin errors++; $display("FAIL rand_gnt_id: cycle %0d got %0d want %0d", cyc, gnt_id_o, eid); end
         checks++; if (ch_ack_o !== ea) begin errors++; $display("FAIL rand_ack: cycle %0d got %b want %b", cyc, ch_ack_o, ea); end
         checks++; if (busy_o !== (m_phase != PH_IDLE)) begin errors++; $display("FAIL rand_busy: cycle %0d got %b want %b", cyc, busy_o, (m_phase != PH_IDLE)); end
         if (m_phase == PH_ACK) $display("random: cycle %0d served ch %0d", cyc, m_gnt);
      end
      eng_ack_i  = 1'b0;
      eng_done_i = 1'b0;
      ch_req_i   = '0;
      ch_en_i    = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_priority();
      test_round_robin();
      test_aging();
      test_abort();
      test_ack_done_same();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
